// File: rtl/baby_pkg.sv
// baby_pkg: shared constants and state type for the Manchester Baby store loader.
//   BABY_WORD_W    store word width
//   BABY_BYTE_W    host byte width
//   BYTES_PER_WORD host bytes packed per store word
//   BYTE_CNT_W     width of a counter over the bytes of one word
//   ram_load_state_t  load sequencer states
package baby_pkg;

  localparam int unsigned BABY_WORD_W    = 32;
  localparam int unsigned BABY_BYTE_W    = 8;
  localparam int unsigned BYTES_PER_WORD = BABY_WORD_W / BABY_BYTE_W;
  localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } ram_load_state_t;

endpackage

// File: rtl/byte_packer.sv
// byte_packer: synchronous byte-to-word shift register. Each loaded byte
// enters at the LSBs, so the first byte of a word ends up in the MSBs.
//   clk    system clock
//   rst    asynchronous active-high reset
//   clear  synchronous clear (has priority over load)
//   load   shift data into the word this cycle
//   data   incoming byte
//   word   packed word (registered)
module byte_packer
  import baby_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   load,
  input  logic [BABY_BYTE_W-1:0] data,
  output logic [BABY_WORD_W-1:0] word
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
    end else if (clear) begin
      word <= '0;
    end else if (load) begin
      word <= {word[BABY_WORD_W-BABY_BYTE_W-1:0], data};
    end
  end

endmodule

// File: rtl/ram_load_ctrl.sv
// ram_load_ctrl: loads WORDS store words from an 8-bit valid/ready byte stream,
// packing four bytes per word (first byte in the MSBs) and writing them to
// consecutive RAM addresses from 0, then pulsing done_o.
// Optional feature macro: RAM_LOAD_CHECKSUM_EN (running modulo-256 byte sum on
// checksum_o; without it checksum_o is constant zero).
//   clock_i       system clock
//   reset_i       asynchronous active-high reset
//   start_i       begin a load run (sampled only in IDLE)
//   byte_i        host data byte
//   byte_valid_i  byte_i is valid
//   byte_ready_o  a byte is accepted this cycle if valid
//   ram_addr_o    RAM write address
//   ram_data_o    RAM write data
//   ram_we_o      single-cycle RAM write strobe
//   busy_o        run in progress
//   done_o        one-cycle end-of-run pulse
//   checksum_o    running byte sum of the current run
module ram_load_ctrl
  import baby_pkg::*;
#(
  parameter int unsigned WORDS  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [BABY_BYTE_W-1:0] byte_i,
  input  logic                   byte_valid_i,
  output logic                   byte_ready_o,
  output logic [ADDR_W-1:0]      ram_addr_o,
  output logic [BABY_WORD_W-1:0] ram_data_o,
  output logic                   ram_we_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [BABY_BYTE_W-1:0] checksum_o
);

  localparam logic [ADDR_W-1:0]     LAST_ADDR = ADDR_W'(WORDS - 1);
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

  ram_load_state_t       state;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic                  accept;
  logic                  start_load;

  // byte_ready_o is only ever high in COLLECT, so the handshake alone qualifies a byte
  assign accept     = byte_valid_i & byte_ready_o;
  assign start_load = (state == IDLE) & start_i;

  // Sequencer: state, counters and all strobes registered together
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      ram_addr_o   <= '0;
      byte_ready_o <= 1'b0;
      ram_we_o     <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      ram_we_o <= 1'b0;
      done_o   <= 1'b0;
      unique case (state)
        IDLE: begin
          byte_cnt <= '0;
          if (start_i) begin
            state        <= COLLECT;
            ram_addr_o   <= '0;
            byte_ready_o <= 1'b1;
            busy_o       <= 1'b1;
          end
        end
        COLLECT: begin
          if (accept) begin
            byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
            if (byte_cnt == LAST_BYTE) begin
              state        <= WRITE;
              byte_ready_o <= 1'b0;
              ram_we_o     <= 1'b1;
            end
          end
        end
        WRITE: begin
          // Address never wraps: the run ends on the last word
          if (ram_addr_o == LAST_ADDR) begin
            state  <= DONE;
            done_o <= 1'b1;
          end else begin
            state        <= COLLECT;
            ram_addr_o   <= ram_addr_o + ADDR_W'(1);
            byte_cnt     <= '0;
            byte_ready_o <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          byte_ready_o <= 1'b0;
          busy_o       <= 1'b0;
        end
      endcase
    end
  end

  // Word assembly; the packer register is the RAM data output
  byte_packer u_packer (
    .clk   (clock_i),
    .rst   (reset_i),
    .clear (start_load),
    .load  (accept),
    .data  (byte_i),
    .word  (ram_data_o)
  );

`ifdef RAM_LOAD_CHECKSUM_EN
  // Modulo-256 sum of accepted bytes; holds after the run until the next start
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      checksum_o <= '0;
    end else if (start_load) begin
      checksum_o <= '0;
    end else if (accept) begin
      checksum_o <= checksum_o + byte_i;
    end
  end
`else
  assign checksum_o = 8'h00;
`endif

endmodule

// File: tb/tb_ram_load_ctrl.sv
// tb_ram_load_ctrl: self-checking bench for ram_load_ctrl (WORDS=3, ADDR_W=2).
// A cycle-level model derives expected words arithmetically from the byte list.
module tb_ram_load_ctrl;

  localparam int unsigned WORDS  = 3;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned NBYTES = WORDS * 4;
  localparam int          BUDGET = 4000;
`ifdef RAM_LOAD_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic              clock_i = 1'b0;
  logic              reset_i;
  logic              start_i;
  logic [7:0]        byte_i;
  logic              byte_valid_i;
  logic              byte_ready_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [31:0]       ram_data_o;
  logic              ram_we_o;
  logic              busy_o;
  logic              done_o;
  logic [7:0]        checksum_o;

  int n_checks = 0;
  int n_errors = 0;
  int wr_count = 0;
  int done_count = 0;
  logic [31:0]       wr_data_q[$];
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [7:0]        stim [NBYTES];

  ram_load_ctrl #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .ram_addr_o   (ram_addr_o),
    .ram_data_o   (ram_data_o),
    .ram_we_o     (ram_we_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .checksum_o   (checksum_o)
  );

  always #5 clock_i = ~clock_i;

  // Record RAM writes and done pulses mid-cycle
  always @(negedge clock_i) begin
    if (ram_we_o === 1'b1) begin
      wr_count++;
      wr_addr_q.push_back(ram_addr_o);
      wr_data_q.push_back(ram_data_o);
    end
    if (done_o === 1'b1) done_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_ck(input int s);
    return CK_EN ? 32'(s % 256) : 32'(0);
  endfunction

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(byte_ready_o), 0);
    check({tag, "_we"},    32'(ram_we_o), 0);
    check({tag, "_busy"},  32'(busy_o), 0);
    check({tag, "_done"},  32'(done_o), 0);
    check({tag, "_addr"},  32'(ram_addr_o), 0);
    check({tag, "_data"},  ram_data_o, 0);
    check({tag, "_ck"},    32'(checksum_o), 0);
  endtask

  task automatic pulse_reset();
    reset_i = 1'b1;
    #1;
    check_all_zero("async_rst");
    step();
    reset_i = 1'b0;
    start_i = 1'b0;
    byte_valid_i = 1'b0;
    step();
  endtask

  // One full run over stim[]. mode 0: valid every cycle, 1: every other cycle, 2: random.
  // Called in IDLE, one time unit after a rising edge.
  task automatic run_load(input int mode, input bit hold_start);
    longint exp_data;
    int sum, idx, cycles, nb, wr0, dn0;
    bit v;
    exp_data = 0; sum = 0; idx = 0; cycles = 0;
    wr0 = wr_count; dn0 = done_count;
    start_i = 1'b1;
    byte_valid_i = 1'b1;
    byte_i = 8'($urandom);
    step();
    if (!hold_start) start_i = 1'b0;
    check("start_busy", 32'(busy_o), 1);
    check("start_addr", 32'(ram_addr_o), 0);
    check("start_data", ram_data_o, 0);
    check("start_ck", 32'(checksum_o), 0);
    for (int w = 0; w < int'(WORDS); w++) begin
      nb = 0;
      while (nb < 4 && cycles < BUDGET) begin
        case (mode)
          0:       v = 1'b1;
          1:       v = (cycles % 2) == 1;
          default: v = $urandom_range(0, 99) < 60;
        endcase
        byte_valid_i = v;
        byte_i = v ? stim[idx] : 8'($urandom);
        check("collect_ready", 32'(byte_ready_o), 1);
        check("collect_we", 32'(ram_we_o), 0);
        check("collect_addr", 32'(ram_addr_o), 32'(w));
        step();
        cycles++;
        if (v) begin
          exp_data = (exp_data * 256 + longint'(stim[idx])) % 64'h1_0000_0000;
          sum += int'(stim[idx]);
          idx++;
          nb++;
        end
        check("shift_data", ram_data_o, 32'(exp_data));
        check("running_ck", 32'(checksum_o), exp_ck(sum));
      end
      check("collect_budget", 32'(cycles < BUDGET), 1);
      // WRITE cycle: a valid byte here must not be consumed
      byte_valid_i = 1'b1;
      byte_i = 8'($urandom);
      check("write_we", 32'(ram_we_o), 1);
      check("write_ready", 32'(byte_ready_o), 0);
      check("write_addr", 32'(ram_addr_o), 32'(w));
      check("write_data", ram_data_o, 32'(exp_data));
      check("write_busy", 32'(busy_o), 1);
      step();
    end
    check("done_pulse", 32'(done_o), 1);
    check("done_busy", 32'(busy_o), 1);
    check("done_ready", 32'(byte_ready_o), 0);
    check("done_we", 32'(ram_we_o), 0);
    check("done_ck", 32'(checksum_o), exp_ck(sum));
    check("done_data", ram_data_o, 32'(exp_data));
    step();
    check("idle_done", 32'(done_o), 0);
    check("idle_busy", 32'(busy_o), 0);
    check("idle_ready", 32'(byte_ready_o), 0);
    check("hold_addr", 32'(ram_addr_o), WORDS - 1);
    check("hold_data", ram_data_o, 32'(exp_data));
    check("hold_ck", 32'(checksum_o), exp_ck(sum));
    check("write_count", 32'(wr_count - wr0), WORDS);
    check("done_count", 32'(done_count - dn0), 1);
    if (hold_start) begin
      step();
      check("rearm_busy", 32'(busy_o), 1);
      check("rearm_ready", 32'(byte_ready_o), 1);
      check("rearm_addr", 32'(ram_addr_o), 0);
      check("rearm_data", ram_data_o, 0);
      check("rearm_ck", 32'(checksum_o), 0);
      start_i = 1'b0;
    end else begin
      step();
      step();
      check("idle_noise_ready", 32'(byte_ready_o), 0);
      check("idle_noise_data", ram_data_o, 32'(exp_data));
      check("no_extra_write", 32'(wr_count - wr0), WORDS);
      check("no_extra_done", 32'(done_count - dn0), 1);
    end
    byte_valid_i = 1'b0;
  endtask

  initial begin
    int wr0;
    reset_i = 1'b1;
    start_i = 1'b0;
    byte_valid_i = 1'b0;
    byte_i = 8'h00;
    step();
    step();
    check_all_zero("reset");
    reset_i = 1'b0;

    // Valid bytes while IDLE are ignored
    byte_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      byte_i = 8'($urandom);
      step();
      check_all_zero("idle_valid");
    end
    byte_valid_i = 1'b0;

    // Directed first word 12 34 56 78, no stalls
    stim[0] = 8'h12; stim[1] = 8'h34; stim[2] = 8'h56; stim[3] = 8'h78;
    for (int i = 4; i < int'(NBYTES); i++) stim[i] = 8'($urandom);
    wr_data_q.delete();
    wr_addr_q.delete();
    run_load(0, 1'b0);
    check("first_word_data", wr_data_q[0], 32'h12345678);
    check("first_word_addr", 32'(wr_addr_q[0]), 0);

    // Incrementing bytes with valid toggling every other cycle
    for (int i = 0; i < int'(NBYTES); i++) stim[i] = 8'(i + 1);
    wr_data_q.delete();
    wr_addr_q.delete();
    run_load(1, 1'b0);
    check("toggle_word1_data", wr_data_q[1], 32'h05060708);
    check("toggle_word1_addr", 32'(wr_addr_q[1]), 1);

    // Random bytes with random stalls
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < int'(NBYTES); i++) stim[i] = 8'($urandom);
      run_load(2, 1'b0);
    end

    // All 0xFF: checksum wraps modulo 256
    for (int i = 0; i < int'(NBYTES); i++) stim[i] = 8'hFF;
    run_load(0, 1'b0);
    check("ff_checksum", 32'(checksum_o), CK_EN ? 32'hF4 : 32'h0);

    // Reset mid-COLLECT after two bytes
    wr0 = wr_count;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    byte_valid_i = 1'b1;
    byte_i = 8'hAB;
    step();
    byte_i = 8'hCD;
    step();
    byte_valid_i = 1'b0;
    check("partial_data", ram_data_o, 32'h0000ABCD);
    check("partial_ck", 32'(checksum_o), exp_ck(32'hAB + 32'hCD));
    pulse_reset();
    check_all_zero("after_collect_rst");
    check("collect_rst_no_write", 32'(wr_count - wr0), 0);
    for (int i = 0; i < int'(NBYTES); i++) stim[i] = 8'($urandom);
    run_load(2, 1'b0);

    // Reset during the WRITE cycle suppresses the write
    wr0 = wr_count;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    byte_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      byte_i = 8'(8'h40 + i);
      step();
    end
    byte_valid_i = 1'b0;
    check("pre_rst_write_data", ram_data_o, 32'h40414243);
    pulse_reset();
    step();
    check_all_zero("after_write_rst");
    check("write_rst_no_write", 32'(wr_count - wr0), 0);

    // start_i held high: one IDLE cycle, then a fresh run from address 0
    for (int i = 0; i < int'(NBYTES); i++) stim[i] = 8'($urandom);
    run_load(2, 1'b1);
    pulse_reset();
    for (int i = 0; i < int'(NBYTES); i++) stim[i] = 8'($urandom);
    run_load(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_load_ctrl.md
# ram_load_ctrl

Single-clock sequencer that fills the Manchester Baby store from an 8-bit host byte stream. It accepts bytes over a valid/ready handshake and packs each group of four into a 32-bit word, first byte in the MSBs. It writes each word to consecutive RAM addresses starting at 0 and signals completion after the last word. It sits between the chip's 8-bit input pins and the RAM write port, and replaces edge-clocked packing with a fully synchronous load path.

## Interface
- `WORDS`, default 32: number of words loaded per run (2..32).
- `ADDR_W`, default 5: RAM address width; `WORDS` ≤ 2^`ADDR_W`.
- `clock_i`  in  1  system clock; all state updates on the rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  begin a load run; sampled only in IDLE.
- `byte_i`  in  8  host data byte.
- `byte_valid_i`  in  1  `byte_i` is valid.
- `byte_ready_o`  out  1  controller accepts a byte this cycle.
- `ram_addr_o`  out  ADDR_W  RAM write address.
- `ram_data_o`  out  32  RAM write data.
- `ram_we_o`  out  1  single-cycle RAM write strobe.
- `busy_o`  out  1  high in any state except IDLE.
- `done_o`  out  1  one-cycle pulse at the end of a run.
- `checksum_o`  out  8  running byte sum; see Configuration.

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - `start_i`=1 → COLLECT.
  - Clears the address counter, byte counter, packer and checksum.
- COLLECT:
  - `byte_ready_o`=1.
  - A byte is accepted on a cycle with `byte_valid_i` & `byte_ready_o`.
  - On acceptance: `ram_data_o` ← {`ram_data_o`[23:0], `byte_i`}; byte counter increments.
  - Acceptance of the 4th byte → WRITE.
- WRITE:
  - `ram_we_o`=1 for exactly this cycle; `byte_ready_o`=0.
  - If `ram_addr_o` = `WORDS`-1 → DONE.
  - Otherwise `ram_addr_o` increments, the byte counter clears, and the state returns to COLLECT.
- DONE: `done_o`=1 for one cycle → IDLE. Address, data and checksum hold until the next start.
- `start_i` outside IDLE is ignored. `start_i` held high re-arms on the IDLE cycle after DONE.
- `byte_valid_i` outside COLLECT is ignored; no byte is consumed.
- Byte order: first accepted byte lands in `ram_data_o`[31:24], the 4th byte in [7:0].
- Address counter never wraps within a run; the run terminates at `WORDS`-1.
- `reset_i` mid-run aborts immediately, even during WRITE. State → IDLE. No partial-word write is issued after reset deasserts.

## Timing
- Reset values:
  - state IDLE
  - `byte_ready_o`=0, `ram_we_o`=0, `busy_o`=0, `done_o`=0
  - `ram_addr_o`=0, `ram_data_o`=0, `checksum_o`=0
- `start_i` high at cycle n → `busy_o` and `byte_ready_o` high from cycle n+1.
- 4th byte accepted at cycle k → `ram_we_o` high at k+1, with the complete `ram_data_o` and the current `ram_addr_o` valid in the same cycle.
- `byte_ready_o` low at k+1; high again at k+2 when more words remain.
- Zero-stall throughput: 5 cycles per word.
- Minimum run: 1 + 5·`WORDS` + 1 cycles from start to `done_o`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `RAM_LOAD_CHECKSUM_EN` defined:
  - `checksum_o` is the modulo-256 sum of all bytes accepted in the current run.
  - It updates the cycle after each acceptance and clears on start.
- Not defined: `checksum_o` is tied to 8'h00 and no adder is built.

## Structure
- Shared package `baby_pkg`:
  - state enum `ram_load_state_t` (IDLE, COLLECT, WRITE, DONE)
  - constants `BABY_WORD_W`=32 and `BABY_BYTE_W`=8
  - `BYTES_PER_WORD`=4
- One sub-module, `byte_packer`: synchronous 8→32 shift register with load-enable and clear.
- The FSM, address counter, byte counter and checksum stay in `ram_load_ctrl`.

## Test plan
- Reset mid-COLLECT after 2 bytes → all outputs 0, state IDLE; a fresh run then writes correct words from address 0.
- Start, then bytes 8'h12, 8'h34, 8'h56, 8'h78 with no stall → `ram_we_o` one cycle later with addr 0, data 32'h12345678; `byte_ready_o` low that cycle.
- `WORDS`=2, bytes 8'h01..8'h08 with `byte_valid_i` toggling every other cycle → writes 32'h01020304 @0 and 32'h05060708 @1, one `done_o` pulse, no extra writes.
- `byte_valid_i` high while IDLE and during WRITE → no byte consumed; packed data unaffected.
- `start_i` held high through a full run → exactly one IDLE cycle after `done_o`, then a new run starting at addr 0.
- `RAM_LOAD_CHECKSUM_EN`, `WORDS`=2, bytes 8'hFF ×8 → `checksum_o`=8'hF8 at `done_o`. Without the macro → `checksum_o`=8'h00 throughout.
